// File: rtl/gpu_arb_pkg.sv
// Shared types for the core-to-memory arbiter: FSM state encoding and sizing constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpu_arb_pkg;

    localparam int N_CORES_MAX = 16;
    localparam int GRANT_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Bundles the per-core request/ack bus and the single memory request/response bus.
// Latency: n/a (wiring only).
// Backpressure: memory side uses mem_req/mem_ready; cores hold core_req until core_ack.
interface core_mem_arbiter_if #(
    parameter int N_CORES = 16,
    parameter int AW      = 16,
    parameter int DW      = 32
);
    logic [N_CORES-1:0]    core_req;
    logic [N_CORES-1:0]    core_we;
    logic [N_CORES*AW-1:0] core_addr;
    logic [N_CORES*DW-1:0] core_wdata;
    logic [N_CORES-1:0]    core_ack;
    logic [DW-1:0]         core_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [AW-1:0]         mem_addr;
    logic [DW-1:0]         mem_wdata;
    logic                  mem_ready;
    logic                  mem_valid;
    logic [DW-1:0]         mem_rdata;

    // Arbiter view: serves the cores, drives the memory.
    modport master (
        input  core_req, core_we, core_addr, core_wdata,
        output core_ack, core_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_valid, mem_rdata
    );

    // Environment view: the cores and the memory around the arbiter.
    modport slave (
        output core_req, core_we, core_addr, core_wdata,
        input  core_ack, core_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_valid, mem_rdata
    );
endinterface

// File: rtl/core_mem_arbiter_rr_select.sv
// Round-robin pick: first requester after 'last', wrapping, with 'last' itself lowest priority.
// Latency: purely combinational.
// Backpressure: none; 'any' tells the caller whether 'winner' is meaningful.
module rr_select
    import gpu_arb_pkg::*;
#(
    parameter int N = N_CORES_MAX
) (
    input  logic [N-1:0]       req,
    input  logic [GRANT_W-1:0] last,
    output logic [GRANT_W-1:0] winner,
    output logic               any
);

    logic [GRANT_W-1:0] idx;
    logic               found;

    // Scan from last+1 upward; the 4-bit add wraps 15 -> 0 on its own.
    always_comb begin
        winner = '0;
        any    = |req;
        found  = 1'b0;
        idx    = last;
        for (int i = 1; i <= N; i++) begin
            idx = last + GRANT_W'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one memory port among 16 cores, round robin, one transaction at a time.
// Latency: request to core_ack is 3 cycles with an always-ready memory; back-to-back grants every 4 cycles.
// Backpressure: holds mem_req and its fields until mem_ready; waits in WAIT for mem_valid.
// Build macro ARB_TIMEOUT_EN bounds WAIT to TIMEOUT cycles and adds the timeout_err pulse.
module core_mem_arbiter
    import gpu_arb_pkg::*;
#(
    parameter int N_CORES = 16,
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    core_mem_arbiter_if.master bus,
    output logic               busy,
    output logic [GRANT_W-1:0] grant_id
`ifdef ARB_TIMEOUT_EN
    ,
    output logic               timeout_err
`endif
);

    // The grant is 4 bits wide, so the core count cannot move; a zero timeout would never leave WAIT.
    if (N_CORES != N_CORES_MAX || TIMEOUT < 1) begin : g_cfg_check
        $error("core_mem_arbiter: N_CORES must be 16 and TIMEOUT at least 1");
    end

    arb_state_t         state;
    arb_state_t         state_nxt;
    logic [GRANT_W-1:0] last_grant;
    logic [GRANT_W-1:0] rr_winner;
    logic               rr_any;
    logic               resp_d;
    logic               arb_go;
    logic               capture;
    logic [DW-1:0]      rdata_q;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   to_cnt;
    logic               to_hit;
`endif

    rr_select #(.N(N_CORES)) u_rr_select (
        .req    (bus.core_req),
        .last   (last_grant),
        .winner (rr_winner),
        .any    (rr_any)
    );

    // Skip arbitration in the IDLE cycle right after RESP: a core that registers its
    // ack still shows the old request there and must not be served twice.
    assign arb_go = (state == IDLE) && rr_any && !resp_d;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; 'capture' marks the cycle that latches the memory response.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        to_hit    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (arb_go) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready) begin
                    if (bus.mem_valid) begin
                        state_nxt = RESP;
                        capture   = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_valid) begin
                    state_nxt = RESP;
                    capture   = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nxt = RESP;
                    to_hit    = 1'b1;
                end
`endif
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winner's request fields, the response data and the round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_id      <= '0;
            last_grant    <= GRANT_W'(N_CORES_MAX - 1);
            resp_d        <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            rdata_q       <= '0;
        end else begin
            resp_d <= (state == RESP);
            if (arb_go) begin
                grant_id      <= rr_winner;
                bus.mem_we    <= bus.core_we[rr_winner];
                bus.mem_addr  <= bus.core_addr[int'(rr_winner) * AW +: AW];
                bus.mem_wdata <= bus.core_wdata[int'(rr_winner) * DW +: DW];
            end
            // Writes hand back zero rather than whatever the memory drives.
            if (capture) begin
                rdata_q <= bus.mem_we ? '0 : bus.mem_rdata;
            end
`ifdef ARB_TIMEOUT_EN
            if (to_hit) begin
                rdata_q <= '0;
            end
`endif
            if (state == RESP) begin
                last_grant <= grant_id;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    // WAIT dwell counter; restarts whenever we are outside WAIT.
    always_ff @(posedge clock) begin
        if (reset || state != WAIT) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // to_hit is only true on the WAIT->RESP edge, so this is high exactly during RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= to_hit;
        end
    end
`endif

    // One-hot ack and response data, present only during RESP.
    always_comb begin
        bus.core_ack   = '0;
        bus.core_rdata = '0;
        if (state == RESP) begin
            bus.core_ack[grant_id] = 1'b1;
            bus.core_rdata         = rdata_q;
        end
    end

    assign bus.mem_req = (state == ISSUE);
    assign busy        = (state != IDLE);

endmodule

// File: doc/core_mem_arbiter.md
CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 SHALL have parameter N_CORES, default 16: number of requesting cores; fixed at 16, so grant_id is 4 bits.
REQ-002 SHALL have parameter AW, default 16: memory address width.
REQ-003 SHALL have parameter DW, default 32: memory data width.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum cycles in WAIT; used only with ARB_TIMEOUT_EN.
REQ-005 SHALL have port clock, input, 1: rising-edge clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port core_req, input, N_CORES: per-core request, held until its core_ack.
REQ-008 SHALL have port core_we, input, N_CORES: per-core write enable; 1 = write, 0 = read.
REQ-009 SHALL have port core_addr, input, N_CORES*AW: packed addresses; core i occupies bits [i*AW +: AW].
REQ-010 SHALL have port core_wdata, input, N_CORES*DW: packed write data, packed like core_addr.
REQ-011 SHALL have port core_ack, output, N_CORES: one-hot completion pulse to the served core.
REQ-012 SHALL have port core_rdata, output, DW: read data, valid while core_ack is nonzero.
REQ-013 SHALL have port mem_req, output, 1: memory request valid.
REQ-014 SHALL have port mem_we, mem_addr, mem_wdata, outputs, 1/AW/DW: registered request fields.
REQ-015 SHALL have port mem_ready, input, 1: memory accepts the request when sampled high with mem_req.
REQ-016 SHALL have port mem_valid, input, 1: response strobe; mem_rdata is valid with it; writes also return mem_valid.
REQ-017 SHALL have port mem_rdata, input, DW: memory read data.
REQ-018 SHALL have port busy, output, 1: state is not IDLE.
REQ-019 SHALL have port grant_id, output, 4: index of the currently served core.

Function
REQ-020 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-021 IDLE: when core_req != 0, SHALL select a winner by round robin, register grant_id, we, addr and wdata, then go to ISSUE; otherwise SHALL stay in IDLE.
REQ-022 Round robin: the search SHALL start at last_grant+1, wrap 15 -> 0 and skip cores with core_req=0; last_grant SHALL update only in RESP.
REQ-023 ISSUE: mem_req=1 with stable fields; on mem_ready=1 SHALL go to WAIT, or directly to RESP if mem_valid=1 in the same cycle.
REQ-024 WAIT: on mem_valid=1 SHALL capture mem_rdata and go to RESP.
REQ-025 RESP: core_ack[grant_id]=1 and core_rdata = captured data for exactly one cycle, then IDLE; a write SHALL return core_rdata=0.
REQ-026 Latency: with mem_ready and mem_valid tied high, core_ack SHALL follow the request edge by 3 cycles (IDLE, ISSUE, RESP).
REQ-027 A core dropping core_req after it is granted SHALL NOT abort the transaction; the ack is still pulsed.
REQ-028 mem_valid outside ISSUE/WAIT SHALL be ignored.
REQ-029 Back-to-back: a new arbitration SHALL occur no earlier than the IDLE cycle following RESP.

Reset
REQ-030 On reset, SHALL set state=IDLE, last_grant=15 (so core 0 has first priority), and clear grant_id, mem_req, mem_we, mem_addr, mem_wdata, core_ack, core_rdata, busy and the timeout counter.
REQ-031 Reset during ISSUE/WAIT SHALL abandon the transaction with no ack; a late mem_valid SHALL be ignored.

Configuration
REQ-032 Macro ARB_TIMEOUT_EN defined: SHALL count cycles in WAIT; on reaching TIMEOUT without mem_valid, SHALL go to RESP with core_rdata=0 and pulse output timeout_err (1 bit) alongside core_ack.
REQ-033 Macro ARB_TIMEOUT_EN undefined: WAIT SHALL be unbounded; port timeout_err and the counter SHALL be absent.

Structure
REQ-034 Package gpu_arb_pkg SHALL hold the FSM state enum (IDLE, ISSUE, WAIT, RESP) and constant N_CORES_MAX=16.
REQ-035 Round-robin selection SHALL be a combinational sub-module rr_select (inputs req, last; outputs winner, any).

Verification
REQ-036 Reset, then core_req=0x0001, mem_ready=mem_valid=1 -> mem_req in cycle 2, core_ack=0x0001 in cycle 3, grant_id=0.
REQ-037 core_req=0xFFFF held, memory always ready/valid -> grants 0,1,2,...,15,0 in order, one ack per 4 cycles.
REQ-038 last_grant=5, core_req=0x0021 -> core 0 wins next (wrap past 15); then core 5.
REQ-039 Read of core 3, mem_ready delayed 4 cycles, mem_valid 6 cycles later with 0xDEADBEEF -> mem_req held stable, core_ack=0x0008, core_rdata=0xDEADBEEF.
REQ-040 ARB_TIMEOUT_EN, TIMEOUT=10, mem_valid never asserted -> timeout_err and core_ack pulse together 10 cycles after WAIT entry, core_rdata=0.
REQ-041 Reset asserted in WAIT, then mem_valid pulse -> no core_ack, state IDLE, core 0 has priority.
